// File: rtl/fifo_param_if.sv
// Handshake and status bundle for fifo_param: the writer/reader side is the master,
// the FIFO itself is the slave.
interface fifo_param_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
);
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] Fifo_Data_in;
    logic [ADDR_WIDTH:0]   umbral_bajo;
    logic [ADDR_WIDTH:0]   umbral_alto;
    logic                  err_clear;

    logic [DATA_WIDTH-1:0] Fifo_Data_out;
    logic                  data_valid;
    logic [ADDR_WIDTH:0]   fill_count;
    logic                  Fifo_Empty;
    logic                  Fifo_Full;
    logic                  Almost_Empty;
    logic                  Almost_Full;
    logic                  Pausa;
    logic                  Error_Fifo;

    modport master (
        output push, pop, Fifo_Data_in, umbral_bajo, umbral_alto, err_clear,
        input  Fifo_Data_out, data_valid, fill_count, Fifo_Empty, Fifo_Full,
               Almost_Empty, Almost_Full, Pausa, Error_Fifo
    );

    modport slave (
        input  push, pop, Fifo_Data_in, umbral_bajo, umbral_alto, err_clear,
        output Fifo_Data_out, data_valid, fill_count, Fifo_Empty, Fifo_Full,
               Almost_Empty, Almost_Full, Pausa, Error_Fifo
    );
endinterface

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with programmable almost-empty/almost-full thresholds,
// hysteretic Pausa back-pressure, sticky overflow/underflow error and registered read data.
module fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input logic          clk,
    input logic          reset_L,
    fifo_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   next_count;
    logic                  is_full;
    logic                  is_empty;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  err_event;

    assign is_full   = (count == DEPTH_CNT);
    assign is_empty  = (count == '0);
    assign wr_ok     = bus.push & (~is_full | bus.pop);
    assign rd_ok     = bus.pop & ~is_empty;
    assign err_event = (bus.push & is_full & ~bus.pop) | (bus.pop & is_empty);

    always_comb begin
        next_count = count;
        if (wr_ok && !rd_ok) begin
            next_count = count + 1'b1;
        end else if (rd_ok && !wr_ok) begin
            next_count = count - 1'b1;
        end
    end

    // Storage is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= bus.Fifo_Data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            bus.Fifo_Data_out <= '0;
            bus.data_valid    <= 1'b0;
            bus.Pausa         <= 1'b0;
            bus.Error_Fifo    <= 1'b0;
        end else begin
            count <= next_count;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr            <= rd_ptr + 1'b1;
                bus.Fifo_Data_out <= mem[rd_ptr];
                bus.data_valid    <= 1'b1;
            end else begin
                bus.data_valid    <= 1'b0;
            end
            // Set takes priority so misprogrammed thresholds still throttle the writer.
            if (next_count >= bus.umbral_alto) begin
                bus.Pausa <= 1'b1;
            end else if (next_count <= bus.umbral_bajo) begin
                bus.Pausa <= 1'b0;
            end
            if (err_event) begin
                bus.Error_Fifo <= 1'b1;
            end else if (bus.err_clear) begin
                bus.Error_Fifo <= 1'b0;
            end
        end
    end

    assign bus.fill_count   = count;
    assign bus.Fifo_Empty   = is_empty;
    assign bus.Fifo_Full    = is_full;
    assign bus.Almost_Empty = (count <= bus.umbral_bajo);
    assign bus.Almost_Full  = (count >= bus.umbral_alto);
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: read data is checked by a scoreboard queue drained
// by an independent monitor, flags are checked right after each edge.
module tb_fifo_param;
    logic clk;
    logic reset_L;
    int   n_compared;
    int   n_failed;
    logic [5:0] exp_q [$];

    fifo_param_if #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) bus ();

    fifo_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock of stimulus; request lines drop again just after the edge.
    task automatic applyStimulus(input logic do_push, input logic do_pop, input logic [5:0] data, input logic clr);
        bus.push         = do_push;
        bus.pop          = do_pop;
        bus.Fifo_Data_in = data;
        bus.err_clear    = clr;
        @(posedge clk);
        #1;
        bus.push      = 1'b0;
        bus.pop       = 1'b0;
        bus.err_clear = 1'b0;
    endtask

    task automatic checkFlags(input string tag, input int fill, input logic empty, input logic full,
                              input logic ae, input logic af, input logic pausa, input logic err);
        checkOutput({tag, " fill_count"},   32'(bus.fill_count),   32'(fill));
        checkOutput({tag, " Fifo_Empty"},   32'(bus.Fifo_Empty),   32'(empty));
        checkOutput({tag, " Fifo_Full"},    32'(bus.Fifo_Full),    32'(full));
        checkOutput({tag, " Almost_Empty"}, 32'(bus.Almost_Empty), 32'(ae));
        checkOutput({tag, " Almost_Full"},  32'(bus.Almost_Full),  32'(af));
        checkOutput({tag, " Pausa"},        32'(bus.Pausa),        32'(pausa));
        checkOutput({tag, " Error_Fifo"},   32'(bus.Error_Fifo),   32'(err));
    endtask

    always @(negedge clk) begin
        if (reset_L && bus.data_valid) begin
            if (exp_q.size() == 0) begin
                n_compared++;
                n_failed++;
                $display("[TB] FAIL unexpected_read: got 0x%0h, expected no data_valid at %0t", bus.Fifo_Data_out, $time);
            end else begin
                checkOutput("read_data", 32'(bus.Fifo_Data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_compared       = 0;
        n_failed         = 0;
        reset_L          = 1'b0;
        bus.push         = 1'b0;
        bus.pop          = 1'b0;
        bus.Fifo_Data_in = '0;
        bus.err_clear    = 1'b0;
        bus.umbral_bajo  = 3'd1;
        bus.umbral_alto  = 3'd3;

        #12;
        checkFlags("in_reset", 0, 1, 0, 1, 0, 0, 0);
        @(negedge clk);
        reset_L = 1'b1;
        applyStimulus(0, 0, 6'h00, 0);
        checkFlags("idle", 0, 1, 0, 1, 0, 0, 0);
        checkOutput("idle data_valid", 32'(bus.data_valid), 32'd0);

        applyStimulus(1, 0, 6'h11, 0);
        checkFlags("push1", 1, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 6'h22, 0);
        checkFlags("push2", 2, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 6'h33, 0);
        checkFlags("push3", 3, 0, 0, 0, 1, 1, 0);
        applyStimulus(1, 0, 6'h2A, 0);
        checkFlags("push4", 4, 0, 1, 0, 1, 1, 0);

        // Overflow must not disturb contents, then clear the sticky flag.
        applyStimulus(1, 0, 6'h05, 0);
        checkFlags("overflow", 4, 0, 1, 0, 1, 1, 1);
        applyStimulus(0, 0, 6'h00, 1);
        checkFlags("err_clear", 4, 0, 1, 0, 1, 1, 0);

        exp_q.push_back(6'h11);
        applyStimulus(0, 1, 6'h00, 0);
        checkFlags("pop1", 3, 0, 0, 0, 1, 1, 0);
        exp_q.push_back(6'h22);
        applyStimulus(0, 1, 6'h00, 0);
        checkFlags("pop2", 2, 0, 0, 0, 0, 1, 0);
        exp_q.push_back(6'h33);
        applyStimulus(0, 1, 6'h00, 0);
        checkFlags("pop3", 1, 0, 0, 1, 0, 0, 0);
        exp_q.push_back(6'h2A);
        applyStimulus(0, 1, 6'h00, 0);
        checkFlags("pop4", 0, 1, 0, 1, 0, 0, 0);

        applyStimulus(1, 0, 6'h01, 0);
        applyStimulus(1, 0, 6'h02, 0);
        applyStimulus(1, 0, 6'h03, 0);
        applyStimulus(1, 0, 6'h04, 0);
        checkFlags("refill", 4, 0, 1, 0, 1, 1, 0);

        exp_q.push_back(6'h01);
        applyStimulus(1, 1, 6'h3F, 0);
        checkFlags("full_push_pop", 4, 0, 1, 0, 1, 1, 0);
        exp_q.push_back(6'h02);
        applyStimulus(0, 1, 6'h00, 0);
        exp_q.push_back(6'h03);
        applyStimulus(0, 1, 6'h00, 0);
        exp_q.push_back(6'h04);
        applyStimulus(0, 1, 6'h00, 0);
        exp_q.push_back(6'h3F);
        applyStimulus(0, 1, 6'h00, 0);
        checkFlags("drain_wrap", 0, 1, 0, 1, 0, 0, 0);

        applyStimulus(1, 1, 6'h07, 0);
        checkFlags("empty_push_pop", 1, 0, 0, 1, 0, 0, 1);
        checkOutput("empty_push_pop data_valid", 32'(bus.data_valid), 32'd0);

        // Thresholds act on the almost flags without waiting for an edge.
        bus.umbral_bajo = 3'd0;
        bus.umbral_alto = 3'd1;
        #1;
        checkOutput("live_bajo Almost_Empty", 32'(bus.Almost_Empty), 32'd0);
        checkOutput("live_alto Almost_Full",  32'(bus.Almost_Full),  32'd1);
        checkOutput("live_alto Pausa",        32'(bus.Pausa),        32'd0);
        bus.umbral_bajo = 3'd1;
        bus.umbral_alto = 3'd3;

        exp_q.push_back(6'h07);
        applyStimulus(0, 1, 6'h00, 0);
        checkFlags("pop_07", 0, 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 1, 6'h00, 1);
        checkFlags("error_beats_clear", 0, 1, 0, 1, 0, 0, 1);
        applyStimulus(0, 0, 6'h00, 1);
        checkFlags("clear_again", 0, 1, 0, 1, 0, 0, 0);

        applyStimulus(1, 1, 6'h15, 0);
        applyStimulus(1, 0, 6'h16, 0);
        applyStimulus(1, 0, 6'h17, 0);
        checkFlags("pre_reset", 3, 0, 0, 0, 1, 1, 1);
        #2;
        reset_L = 1'b0;
        #1;
        checkFlags("async_reset", 0, 1, 0, 1, 0, 0, 0);
        checkOutput("async_reset Fifo_Data_out", 32'(bus.Fifo_Data_out), 32'd0);
        checkOutput("async_reset data_valid",    32'(bus.data_valid),    32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        applyStimulus(0, 0, 6'h00, 0);
        checkFlags("post_reset", 0, 1, 0, 1, 0, 0, 0);

        @(negedge clk);
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end
endmodule
